dmgplus_splash_loader: RTL

DMGPLUS_SPLASH_LOADER -- requirements
Module: dmgplus_splash_loader

---
 rtl/dmgplus_splash_loader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmgplus_splash_loader.sv
// Validates the DMG+ ROM signature, reads the hold delay, and streams the splash image into VRAM.
// Build option: define DMGPLUS_SPLASH_SKIP_EN to add the skip input that ends the HOLD phase early.
module dmgplus_splash_loader #(
    parameter int          H_PIX    = 160,
    parameter int          V_PIX    = 144,
    parameter int          BPP      = 2,
    parameter logic [15:0] IMG_BASE = 16'h0134,
    parameter logic [15:0] DLY_ADDR = 16'h00FE
) (
    input  logic           clk_8m,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           frame_start,
`ifdef DMGPLUS_SPLASH_SKIP_EN
    input  logic           skip,
`endif
    output logic [15:0]    rom_addr,
    output logic           rom_rd,
    input  logic [7:0]     rom_data,
    input  logic           rom_bsy,
    output logic           vramclk,
    output logic [15:0]    vramaddr,
    output logic [BPP-1:0] vramdata,
    output logic           vramwe,
    output logic           is_dmgplus,
    output logic           rom_read_done,
    output logic           splash_done
);

    localparam int         PPB    = 8 / BPP;
    localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
    localparam logic [7:0] Y_LAST = 8'(V_PIX - 1);

    typedef enum logic [2:0] {IDLE, SIG, DLY, IMG, HOLD, DONE} state_t;
    typedef enum logic [1:0] {RD_ISSUE, RD_STROBE, RD_GAP, RD_WAIT} rd_t;

    state_t         state_reg;
    rd_t            rd_reg;
    logic [15:0]    rom_addr_reg;
    logic           rom_rd_reg;
    logic [1:0]     idx_reg;
    logic           match_reg;
    logic [15:0]    dly_reg;
    logic [15:0]    frm_reg;
    logic [15:0]    img_addr_reg;
    logic [7:0]     shift_reg;
    logic [3:0]     pix_left_reg;
    logic           last_px_reg;
    logic           hold_arm_reg;
    logic [7:0]     x_reg;
    logic [7:0]     y_reg;
    logic [15:0]    vramaddr_reg;
    logic [BPP-1:0] vramdata_reg;
    logic           vramwe_reg;
    logic           is_dmgplus_reg;
    logic           rom_read_done_reg;
    logic           splash_done_reg;

    logic [7:0]     sig_byte;
    logic [15:0]    rd_addr;
    logic           rd_active;

    always_comb begin
        sig_byte = 8'h2B;
        case (idx_reg)
            2'd0:    sig_byte = 8'h44;
            2'd1:    sig_byte = 8'h4D;
            2'd2:    sig_byte = 8'h47;
            default: sig_byte = 8'h2B;
        endcase
    end

    always_comb begin
        rd_addr = img_addr_reg;
        case (state_reg)
            SIG:     rd_addr = 16'h0100 + 16'(idx_reg);
            DLY:     rd_addr = DLY_ADDR + 16'(idx_reg);
            default: rd_addr = img_addr_reg;
        endcase
    end

    // The read engine only runs when no pixels of the current byte remain to be written.
    assign rd_active = (state_reg == SIG) || (state_reg == DLY) ||
                       ((state_reg == IMG) && (pix_left_reg == 4'd0) && !last_px_reg);

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rd_reg            <= RD_ISSUE;
            rom_addr_reg      <= 16'h0100;
            rom_rd_reg        <= 1'b0;
            idx_reg           <= 2'd0;
            match_reg         <= 1'b1;
            dly_reg           <= 16'h0000;
            frm_reg           <= 16'h0000;
            img_addr_reg      <= IMG_BASE;
            shift_reg         <= 8'h00;
            pix_left_reg      <= 4'd0;
            last_px_reg       <= 1'b0;
            hold_arm_reg      <= 1'b0;
            x_reg             <= 8'd0;
            y_reg             <= 8'd0;
            vramaddr_reg      <= 16'h0000;
            vramdata_reg      <= '0;
            vramwe_reg        <= 1'b0;
            is_dmgplus_reg    <= 1'b1;
            rom_read_done_reg <= 1'b0;
            splash_done_reg   <= 1'b0;
        end else begin
            rom_rd_reg <= 1'b0;
            vramwe_reg <= 1'b0;
            if (rd_active) begin
                case (rd_reg)
                    RD_ISSUE: begin
                        rom_rd_reg   <= 1'b1;
                        rom_addr_reg <= rd_addr;
                        rd_reg       <= RD_STROBE;
                    end
                    RD_STROBE: rd_reg <= RD_GAP;
                    RD_GAP:    rd_reg <= RD_WAIT;
                    default: if (!rom_bsy) begin
                        rd_reg <= RD_ISSUE;
                        case (state_reg)
                            SIG: begin
                                if (rom_data != sig_byte)
                                    match_reg <= 1'b0;
                                if (idx_reg == 2'd3) begin
                                    idx_reg <= 2'd0;
                                    if (match_reg && (rom_data == sig_byte)) begin
                                        state_reg <= DLY;
                                    end else begin
                                        is_dmgplus_reg    <= 1'b0;
                                        rom_read_done_reg <= 1'b1;
                                        splash_done_reg   <= 1'b1;
                                        state_reg         <= DONE;
                                    end
                                end else begin
                                    idx_reg <= idx_reg + 2'd1;
                                end
                            end
                            DLY: begin
                                if (idx_reg == 2'd0) begin
                                    dly_reg[15:8] <= rom_data;
                                    idx_reg       <= 2'd1;
                                end else begin
                                    dly_reg[7:0]  <= rom_data;
                                    idx_reg       <= 2'd0;
                                    img_addr_reg  <= IMG_BASE;
                                    state_reg     <= IMG;
                                end
                            end
                            default: begin
                                shift_reg    <= rom_data;
                                pix_left_reg <= 4'(PPB);
                                img_addr_reg <= img_addr_reg + 16'd1;
                            end
                        endcase
                    end
                endcase
            end else begin
                case (state_reg)
                    IDLE: if (ena) begin
                        state_reg <= SIG;
                        idx_reg   <= 2'd0;
                        match_reg <= 1'b1;
                        rd_reg    <= RD_ISSUE;
                    end
                    IMG: begin
                        if (pix_left_reg != 4'd0) begin
                            vramwe_reg   <= 1'b1;
                            vramdata_reg <= shift_reg[7 -: BPP];
                            vramaddr_reg <= {y_reg, x_reg};
                            shift_reg    <= {shift_reg[7-BPP:0], {BPP{1'b0}}};
                            pix_left_reg <= pix_left_reg - 4'd1;
                            if (x_reg == X_LAST) begin
                                x_reg <= 8'd0;
                                y_reg <= y_reg + 8'd1;
                                if (y_reg == Y_LAST)
                                    last_px_reg <= 1'b1;
                            end else begin
                                x_reg <= x_reg + 8'd1;
                            end
                        end else begin
                            // One cycle after the final write: report completion.
                            last_px_reg       <= 1'b0;
                            rom_read_done_reg <= 1'b1;
                            frm_reg           <= 16'h0000;
                            hold_arm_reg      <= 1'b0;
                            if (dly_reg == 16'h0000) begin
                                splash_done_reg <= 1'b1;
                                state_reg       <= DONE;
                            end else begin
                                state_reg <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        hold_arm_reg <= 1'b1;
`ifdef DMGPLUS_SPLASH_SKIP_EN
                        if (skip) begin
                            splash_done_reg <= 1'b1;
                            state_reg       <= DONE;
                        end else
`endif
                        if (frame_start && hold_arm_reg) begin
                            if (frm_reg + 16'd1 == dly_reg) begin
                                splash_done_reg <= 1'b1;
                                state_reg       <= DONE;
                            end else begin
                                frm_reg <= frm_reg + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vramclk       = clk_8m;
    assign rom_addr      = rom_addr_reg;
    assign rom_rd        = rom_rd_reg;
    assign vramaddr      = vramaddr_reg;
    assign vramdata      = vramdata_reg;
    assign vramwe        = vramwe_reg;
    assign is_dmgplus    = is_dmgplus_reg;
    assign rom_read_done = rom_read_done_reg;
    assign splash_done   = splash_done_reg;

endmodule
